// File: rtl/sync_fork_param.sv
// Eager fork: one upstream handshake fans out to SIZE branches.
// Each branch completes independently; done_cnt counts finished jobs.
module sync_fork_param #(
  parameter int SIZE      = 2,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_in,
  output logic                 ack_in,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [SIZE-1:0]      mask_in,
  output logic [SIZE-1:0]      req_out,
  input  logic [SIZE-1:0]      ack_out,
  output logic [WIDTH-1:0]     data_out,
  output logic [CNT_WIDTH-1:0] done_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [SIZE-1:0]      pend_q, pend_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic [SIZE-1:0]      xfer;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    xfer    = pend_q & ack_out;
    unique case (state_q)
      IDLE: begin
        // ack_q gates acceptance so the cycle after reset takes nothing
        if (ack_q && req_in) begin
          if (|mask_in) begin
            data_d  = data_in;
            pend_d  = mask_in;
            state_d = BUSY;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      BUSY: begin
        pend_d = pend_q & ~xfer;
        if (pend_d == '0) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_in   = ack_q;
  assign req_out  = pend_q;
  assign data_out = data_q;
  assign done_cnt = cnt_q;

endmodule

// File: doc/sync_fork_param.md
SYNC_FORK_PARAM -- requirements
Module: sync_fork_param

Interface
REQ-001 Parameter SIZE, default 2, number of output branches; legal range 1..32.
REQ-002 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-003 Parameter CNT_WIDTH, default 16, width of the completed-transaction counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  1  upstream request (valid).
REQ-007 ack_in  output  1  upstream acknowledge (ready); a transfer occurs in any cycle with req_in=1 and ack_in=1.
REQ-008 data_in  input  WIDTH  upstream payload.
REQ-009 mask_in  input  SIZE  branch-enable mask, sampled with data_in; bit i=1 forks the payload to branch i.
REQ-010 req_out  output  SIZE  per-branch request.
REQ-011 ack_out  input  SIZE  per-branch acknowledge; branch i transfers in any cycle with req_out[i]=1 and ack_out[i]=1.
REQ-012 data_out  output  WIDTH  held payload, broadcast to all branches.
REQ-013 done_cnt  output  CNT_WIDTH  count of completed upstream transactions.

Function
REQ-014 Two states: IDLE and BUSY; ack_in SHALL be 1 exactly when in IDLE (registered, no combinational path from ack_out).
REQ-015 IDLE, req_in=1, mask_in!=0: capture data_in into data register and mask_in into pending register; enter BUSY at the next edge.
REQ-016 IDLE, req_in=1, mask_in=0: transaction accepted and discarded; stay IDLE; done_cnt increments; data register unchanged.
REQ-017 BUSY: req_out = pending (eager fork); each branch is offered independently, with no ordering between branches.
REQ-018 BUSY, on branch i transfer: clear pending[i] at that edge; req_out[i] drops the following cycle; the branch is never offered the same payload twice.
REQ-019 Multiple branches transferring in the same cycle SHALL all clear in that cycle.
REQ-020 When all pending bits clear at an edge (including the case where the last branches clear simultaneously): enter IDLE and increment done_cnt at that same edge.
REQ-021 Latency: upstream transfer at edge k gives req_out valid in the cycle after edge k; minimum spacing between upstream transfers is 2 cycles.
REQ-022 data_out SHALL remain stable while in BUSY; in IDLE it holds the last captured value.
REQ-023 ack_out[i] asserted while req_out[i]=0 SHALL be ignored.
REQ-024 req_in, data_in and mask_in SHALL be ignored while in BUSY.
REQ-025 done_cnt wraps modulo 2^CNT_WIDTH, from all-ones to 0 without saturation or flag.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, pending=0, req_out=0, data_out=0, done_cnt=0, and ack_in=0 while rst is low.
REQ-027 ack_in SHALL rise in the first cycle after rst deasserts; reset asserted mid-BUSY aborts the transaction without incrementing done_cnt.

Verification
REQ-028 SIZE=2: req_in=1, data_in=0xA5, mask_in=2'b11, ack_out=2'b11 -> req_out=2'b11 one cycle, data_out=0xA5, ack_in returns 1 next cycle, done_cnt=1.
REQ-029 SIZE=2, mask 2'b11: ack_out=2'b01 then 2'b10 on successive cycles -> req_out 2'b11, 2'b10, 2'b00; branch 0 not re-offered; done_cnt increments once.
REQ-030 mask_in=2'b10 -> req_out[0] stays 0 throughout; ack_out[0]=1 pulses have no effect; completes on the ack_out[1] transfer.
REQ-031 mask_in=0 with req_in=1 in IDLE -> no req_out activity, state stays IDLE, done_cnt+1; in BUSY, toggling req_in/data_in -> data_out unchanged.
REQ-032 rst low for 1 cycle while BUSY with pending=2'b01 -> req_out=0 and done_cnt=0 immediately, ack_in=1 in the first cycle after release.
REQ-033 CNT_WIDTH=4: 17 transactions -> done_cnt reads 15 then 0 then 1.
